// File: rtl/arbiter_rr_nx1.sv
// arbiter_rr_nx1: N-way round-robin bus arbiter with an LR/SC reservation lock.
// Outputs are muxed combinationally from the grant register.
module arbiter_rr_nx1 #(
    parameter int N_REQ        = 4,
    parameter int XLEN         = 32,
    parameter int ID_W         = $clog2(N_REQ),
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_REQ-1:0]      i_bus_en,
    input  logic [N_REQ-1:0]      i_wr_en,
    input  logic [N_REQ*XLEN-1:0] i_wr_data,
    input  logic [N_REQ*XLEN-1:0] i_addr,
    input  logic [N_REQ*4-1:0]    i_byte_en,
    input  logic [N_REQ-1:0]      i_atomic,
    input  logic [N_REQ*7-1:0]    i_operation,
    output logic [N_REQ-1:0]      o_ack,
    output logic [N_REQ*XLEN-1:0] o_rd_data,
    input  logic                  i_ack,
    input  logic [XLEN-1:0]       i_rd_data,
    output logic [ID_W-1:0]       o_id,
    output logic                  o_bus_en,
    output logic                  o_wr_en,
    output logic [XLEN-1:0]       o_wr_data,
    output logic [XLEN-1:0]       o_addr,
    output logic [3:0]            o_byte_en,
    output logic                  o_atomic,
    output logic [6:0]            o_operation
);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t           state_q;
    logic [ID_W-1:0]  grant_q, last_q, lock_id_q, sel, idx;
    logic             lock_v_q, found, busy, ack_cyc, is_lr, is_sc;
    logic [CNT_W-1:0] lock_cnt_q;
    logic [N_REQ-1:0] mask;
    logic [6:0]       op_g;

    assign mask = lock_v_q ? i_bus_en & (N_REQ'(1) << lock_id_q) : i_bus_en;

    // Scan from farthest to nearest so the index right after last_q is written last and wins.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last_q) + k) % N_REQ);
            if (mask[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign busy    = state_q == BUSY;
    assign ack_cyc = busy && i_ack;
    assign op_g    = i_operation[grant_q*7 +: 7];
    assign is_lr   = i_atomic[grant_q] && op_g[6:2] == 5'b00010;
    assign is_sc   = i_atomic[grant_q] && op_g[6:2] == 5'b00011;

    assign o_id        = grant_q;
    assign o_bus_en    = busy && i_bus_en[grant_q];
    assign o_wr_en     = busy && i_wr_en[grant_q];
    assign o_atomic    = busy && i_atomic[grant_q];
    assign o_wr_data   = busy ? i_wr_data[grant_q*XLEN +: XLEN] : '0;
    assign o_addr      = busy ? i_addr[grant_q*XLEN +: XLEN] : '0;
    assign o_byte_en   = busy ? i_byte_en[grant_q*4 +: 4] : '0;
    assign o_operation = busy ? op_g : '0;
    assign o_ack       = ack_cyc ? N_REQ'(1) << grant_q : '0;
    assign o_rd_data   = busy ? (N_REQ*XLEN)'(i_rd_data) << (grant_q*XLEN) : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= ID_W'(N_REQ - 1);
            lock_v_q   <= 1'b0;
            lock_id_q  <= '0;
            lock_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    grant_q <= sel;
                    last_q  <= sel;
                    state_q <= BUSY;
                end
                BUSY: if (i_ack) state_q <= RELEASE;
                      else if (!i_bus_en[grant_q]) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            // An LR ack re-arms the lock even on the cycle it would have expired.
            if (ack_cyc && is_lr) begin
                lock_v_q   <= 1'b1;
                lock_id_q  <= grant_q;
                lock_cnt_q <= '0;
            end else if (ack_cyc && is_sc && grant_q == lock_id_q) begin
                lock_v_q <= 1'b0;
            end else if (!ack_cyc && lock_v_q) begin
                if (lock_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) lock_v_q <= 1'b0;
                else lock_cnt_q <= lock_cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_arbiter_rr_nx1.sv
// tb_arbiter_rr_nx1: scoreboard bench; stimulus queues expected grants/acks, a monitor pops them on DUT events.
module tb_arbiter_rr_nx1;
    localparam int N = 4, X = 32, IW = 2, LT = 8;

    logic            i_clk = 1'b0, i_rst = 1'b1;
    logic [N-1:0]    i_bus_en = '0, i_wr_en = '0, i_atomic = '0;
    logic [N*X-1:0]  i_wr_data = '0, i_addr = '0;
    logic [N*4-1:0]  i_byte_en = '0;
    logic [N*7-1:0]  i_operation = '0;
    logic            i_ack = 1'b0;
    logic [X-1:0]    i_rd_data = '0;
    logic [N-1:0]    o_ack;
    logic [N*X-1:0]  o_rd_data;
    logic [IW-1:0]   o_id;
    logic            o_bus_en, o_wr_en, o_atomic;
    logic [X-1:0]    o_wr_data, o_addr;
    logic [3:0]      o_byte_en;
    logic [6:0]      o_operation;

    arbiter_rr_nx1 #(.N_REQ(N), .XLEN(X), .LOCK_TIMEOUT(LT)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_bus_en(i_bus_en), .i_wr_en(i_wr_en),
        .i_wr_data(i_wr_data), .i_addr(i_addr), .i_byte_en(i_byte_en), .i_atomic(i_atomic),
        .i_operation(i_operation), .o_ack(o_ack), .o_rd_data(o_rd_data), .i_ack(i_ack),
        .i_rd_data(i_rd_data), .o_id(o_id), .o_bus_en(o_bus_en), .o_wr_en(o_wr_en),
        .o_wr_data(o_wr_data), .o_addr(o_addr), .o_byte_en(o_byte_en), .o_atomic(o_atomic),
        .o_operation(o_operation)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] addr;
        logic        we, at;
        logic [6:0]  op;
        int          gmin, gmax;
    } g_t;
    typedef struct {
        logic [3:0]   ack;
        logic [127:0] rd;
    } a_t;

    g_t gq[$];
    a_t aq[$];
    int n_vec = 0, n_err = 0, cyc = 0, last_ack = 0, bcnt = 0;
    logic auto_ack = 1'b0, man_ack = 1'b0;
    logic [31:0] rd_val = '0, man_rd = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #2;
        end
    endtask

    task automatic set_req(input int r, input logic en, input logic we, input logic [31:0] addr,
                           input logic at, input logic [6:0] op);
        i_bus_en[r]          = en;
        i_wr_en[r]           = we;
        i_addr[r*32 +: 32]   = addr;
        i_wr_data[r*32 +: 32] = 32'hC0DE_0000 + 32'(r);
        i_byte_en[r*4 +: 4]  = 4'b0001 << r;
        i_atomic[r]          = at;
        i_operation[r*7 +: 7] = op;
    endtask

    task automatic push_g(input int id, input logic [31:0] addr, input logic we, input logic at,
                          input logic [6:0] op, input int gmin, input int gmax);
        g_t g;
        g.id = 2'(id); g.addr = addr; g.we = we; g.at = at; g.op = op; g.gmin = gmin; g.gmax = gmax;
        gq.push_back(g);
    endtask

    task automatic push_a(input int id, input logic [31:0] v);
        a_t a;
        a.ack = 4'b0001 << id;
        a.rd  = {96'h0, v} << (id * 32);
        aq.push_back(a);
    endtask

    task automatic wait_q(input int na, input int ng, input int lim, input string nm);
        int k = 0;
        while ((aq.size() > na || gq.size() > ng) && k < lim) begin
            step(1);
            k++;
        end
        n_vec++;
        if (aq.size() > na || gq.size() > ng) begin
            n_err++;
            $display("FAIL timeout_%s: pending acks %0d grants %0d after %0d cycles", nm, aq.size(), gq.size(), lim);
        end
    endtask

    // Downstream model: ack arrives in the second cycle of each transaction.
    initial forever begin
        @(posedge i_clk);
        #1;
        bcnt = o_bus_en ? bcnt + 1 : 0;
        i_ack     = auto_ack ? (bcnt == 2) : man_ack;
        i_rd_data = auto_ack ? ((bcnt == 2) ? rd_val : 32'h0) : man_rd;
    end

    initial begin : monitor
        logic prev_en;
        g_t g;
        a_t a;
        logic [3:0] be;
        prev_en = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_bus_en && !prev_en) begin
                if (gq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_grant: got o_id=%0d expected no grant", o_id);
                end else begin
                    g = gq.pop_front();
                    be = 4'b0001 << g.id;
                    chk("grant_id", o_id, g.id);
                    chk("grant_addr", o_addr, g.addr);
                    chk("grant_fields", {o_wr_en, o_atomic, o_operation, o_byte_en, o_wr_data},
                        {g.we, g.at, g.op, be, 32'hC0DE_0000 + 32'(g.id)});
                    if (g.gmax >= 0) begin
                        n_vec++;
                        if (cyc - last_ack < g.gmin || cyc - last_ack > g.gmax) begin
                            n_err++;
                            $display("FAIL grant_gap: got %0d cycles after ack expected %0d..%0d",
                                     cyc - last_ack, g.gmin, g.gmax);
                        end
                    end
                end
            end
            prev_en = o_bus_en;
            if (o_ack != '0) begin
                if (aq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_ack: got o_ack=%b expected 0000", o_ack);
                end else begin
                    a = aq.pop_front();
                    chk("ack_vec", o_ack, a.ack);
                    chk("rd_data", o_rd_data, a.rd);
                end
                last_ack = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1);
    end

    initial begin
        step(2);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_bus_en", o_bus_en, 0);
        chk("rst_id", o_id, 0);
        chk("rst_ack", o_ack, 0);
        chk("rst_rd", o_rd_data, 0);
        chk("rst_fields", {o_wr_en, o_atomic, o_operation, o_byte_en, o_wr_data, o_addr}, 0);
        step(1);

        // round robin with everyone requesting
        rd_val = 32'h5A5A_0001;
        auto_ack = 1'b1;
        for (int r = 0; r < N; r++) set_req(r, 1'b1, r == 3, 32'h1000 + 32'(r * 16), 1'b0, 7'h00);
        push_g(0, 32'h1000, 0, 0, 7'h00, -1, -1);
        push_g(1, 32'h1010, 0, 0, 7'h00, 3, 3);
        push_g(2, 32'h1020, 0, 0, 7'h00, 3, 3);
        push_g(3, 32'h1030, 1, 0, 7'h00, 3, 3);
        push_g(0, 32'h1000, 0, 0, 7'h00, 3, 3);
        push_a(0, rd_val); push_a(1, rd_val); push_a(2, rd_val); push_a(3, rd_val); push_a(0, rd_val);
        wait_q(0, 0, 100, "rr");
        i_bus_en = '0;
        step(2);

        // read data routed to requester 2 only
        rd_val = 32'hDEAD_BEEF;
        set_req(2, 1'b1, 1'b0, 32'h100, 1'b0, 7'h00);
        push_g(2, 32'h100, 0, 0, 7'h00, -1, -1);
        push_a(2, rd_val);
        wait_q(0, 0, 30, "route");
        i_bus_en = '0;
        step(2);

        // LR by 1 holds off 0/2/3 until its SC
        rd_val = 32'h1111_2222;
        set_req(1, 1'b1, 1'b0, 32'h200, 1'b1, 7'h08);
        push_g(1, 32'h200, 0, 1, 7'h08, -1, -1);
        push_a(1, rd_val);
        wait_q(1, 0, 30, "lr_grant");
        set_req(0, 1'b1, 1'b1, 32'h300, 1'b0, 7'h00);
        set_req(2, 1'b1, 1'b0, 32'h320, 1'b0, 7'h00);
        set_req(3, 1'b1, 1'b0, 32'h330, 1'b0, 7'h00);
        push_g(1, 32'h200, 0, 1, 7'h0C, 3, 3);
        push_g(2, 32'h320, 0, 0, 7'h00, 3, 3);
        push_g(3, 32'h330, 0, 0, 7'h00, 3, 3);
        push_g(0, 32'h300, 1, 0, 7'h00, 3, 3);
        push_a(1, rd_val); push_a(2, rd_val); push_a(3, rd_val); push_a(0, rd_val);
        wait_q(4, 4, 30, "lr_ack");
        set_req(1, 1'b1, 1'b0, 32'h200, 1'b1, 7'h0C);
        wait_q(0, 0, 100, "sc_seq");
        i_bus_en = '0;
        step(2);

        // lock left by an idle LR owner expires
        set_req(1, 1'b1, 1'b0, 32'h400, 1'b1, 7'h08);
        push_g(1, 32'h400, 0, 1, 7'h08, -1, -1);
        push_a(1, rd_val);
        wait_q(0, 0, 30, "lr2");
        set_req(1, 1'b0, 1'b0, 32'h400, 1'b0, 7'h00);
        set_req(0, 1'b1, 1'b0, 32'h500, 1'b0, 7'h00);
        push_g(0, 32'h500, 0, 0, 7'h00, 8, 10);
        push_a(0, rd_val);
        wait_q(0, 0, 60, "timeout");
        i_bus_en = '0;
        step(2);

        // abort in BUSY, then spurious ack in IDLE
        auto_ack = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h600, 1'b0, 7'h00);
        push_g(0, 32'h600, 0, 0, 7'h00, -1, -1);
        wait_q(0, 0, 30, "abort_grant");
        set_req(0, 1'b0, 1'b0, 32'h600, 1'b0, 7'h00);
        @(negedge i_clk);
        chk("abort_bus_en", o_bus_en, 0);
        @(negedge i_clk);
        chk("abort_idle_bus_en", o_bus_en, 0);
        chk("abort_ack", o_ack, 0);
        step(1);
        man_ack = 1'b1;
        man_rd  = 32'hFFFF_FFFF;
        step(1);
        repeat (3) begin
            @(negedge i_clk);
            chk("spur_ack", o_ack, 0);
            chk("spur_rd", o_rd_data, 0);
        end
        step(1);
        man_ack = 1'b0;
        man_rd  = '0;
        step(2);
        auto_ack = 1'b1;
        rd_val = 32'h0000_2222;
        set_req(2, 1'b1, 1'b0, 32'h700, 1'b0, 7'h00);
        push_g(2, 32'h700, 0, 0, 7'h00, -1, -1);
        push_a(2, rd_val);
        wait_q(0, 0, 30, "after_abort");
        i_bus_en = '0;
        step(2);

        // reset during the locked owner's SC
        set_req(1, 1'b1, 1'b0, 32'h800, 1'b1, 7'h08);
        push_g(1, 32'h800, 0, 1, 7'h08, -1, -1);
        push_a(1, rd_val);
        wait_q(0, 0, 30, "lr3");
        set_req(1, 1'b1, 1'b0, 32'h800, 1'b1, 7'h0C);
        auto_ack = 1'b0;
        push_g(1, 32'h800, 0, 1, 7'h0C, 3, 3);
        wait_q(0, 0, 30, "sc3_grant");
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_mid_bus_en", o_bus_en, 0);
        chk("rst_mid_id", o_id, 0);
        chk("rst_mid_ack", o_ack, 0);
        chk("rst_mid_fields", {o_wr_en, o_atomic, o_operation, o_byte_en, o_wr_data, o_addr}, 0);
        step(1);
        i_rst = 1'b0;
        auto_ack = 1'b1;
        rd_val = 32'h3333_4444;
        set_req(1, 1'b0, 1'b0, 32'h800, 1'b0, 7'h00);
        set_req(0, 1'b1, 1'b0, 32'h900, 1'b0, 7'h00);
        set_req(2, 1'b1, 1'b0, 32'hA00, 1'b0, 7'h00);
        set_req(3, 1'b1, 1'b0, 32'hB00, 1'b0, 7'h00);
        push_g(0, 32'h900, 0, 0, 7'h00, -1, -1);
        push_a(0, rd_val);
        wait_q(0, 0, 30, "post_rst");
        i_bus_en = '0;
        step(3);

        chk("queues_empty", 128'(gq.size() + aq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
